// File: rtl/kbd_fifo_intf.sv
// PS/2 keyboard front end: decodes E0/F0/E1 scan sequences, tracks modifiers,
// and queues make events with a modifier snapshot in a first-word-fall-through FIFO.
module kbd_fifo_intf #(
  parameter int         DEPTH_LOG2    = 3,
  parameter logic [7:0] STOP_CODE     = 8'h07,
  parameter int         STOP_PULSE    = 256,
  parameter bit         PAUSE_IS_STOP = 1'b1,
  parameter bit         FILTER_REPEAT = 1'b1
) (
  input  logic                  mclk25,
  input  logic                  reset_in,
  input  logic [7:0]            scan_code,
  input  logic                  scan_dav,
  input  logic                  scan_err,
  input  logic                  read_kb,
  input  logic                  ovf_clr,
  output logic [7:0]            key_code,
  output logic                  key_ext,
  output logic                  key_shift,
  output logic                  key_ctrl,
  output logic                  key_alt,
  output logic                  kbd_available,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic                  shift,
  output logic                  ctrl,
  output logic                  alt,
  output logic                  key_down,
  output logic                  key_stop
);

  localparam int                DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] ONE_LEVEL  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [15:0]       STOP_LOAD  = 16'(STOP_PULSE);

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK, S_PAUSE} dec_state_t;

  dec_state_t              state;
  logic [2:0]              skip_cnt;
  logic [5:0]              mods;
  logic [8:0]              last_make;
  logic [15:0]             stop_cnt;
  logic [11:0]             mem [DEPTH];
  logic [11:0]             head;
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr, rd_next;
  logic [DEPTH_LOG2:0]     count;

  logic        ev_make, ev_break, ev_ext, pause_done, is_prefix, is_mod;
  logic [5:0]  mod_sel;
  logic [8:0]  key_id;
  logic        repeat_hit, push_req, push_ok, pop, full, stop_trig;
  logic [11:0] push_data;

  // Classify the incoming byte as a make or break event given the prefix state.
  always_comb begin
    ev_make    = 1'b0;
    ev_break   = 1'b0;
    ev_ext     = 1'b0;
    pause_done = 1'b0;
    if (scan_dav && !scan_err) begin
      case (state)
        S_IDLE:    ev_make = !is_prefix;
        S_EXT:     begin ev_make = !is_prefix; ev_ext = 1'b1; end
        S_BRK:     ev_break = 1'b1;
        S_EXT_BRK: begin ev_break = 1'b1; ev_ext = 1'b1; end
        S_PAUSE:   pause_done = (skip_cnt == 3'd1);
        default:   ;
      endcase
    end
  end

  assign is_prefix  = (scan_code == 8'hE0) || (scan_code == 8'hF0) || (scan_code == 8'hE1);
  // Bit order: lshift, rshift, lctrl, rctrl, lalt, ralt.
  assign mod_sel[0] = !ev_ext && (scan_code == 8'h12);
  assign mod_sel[1] = !ev_ext && (scan_code == 8'h59);
  assign mod_sel[2] = !ev_ext && (scan_code == 8'h14);
  assign mod_sel[3] =  ev_ext && (scan_code == 8'h14);
  assign mod_sel[4] = !ev_ext && (scan_code == 8'h11);
  assign mod_sel[5] =  ev_ext && (scan_code == 8'h11);
  assign is_mod     = |mod_sel;

  assign shift = mods[0] | mods[1];
  assign ctrl  = mods[2] | mods[3];
  assign alt   = mods[4] | mods[5];

  assign key_id     = {ev_ext, scan_code};
  assign repeat_hit = FILTER_REPEAT && key_down && (key_id == last_make);
  assign push_req   = ev_make && !is_mod && !repeat_hit;
  assign stop_trig  = (push_req && !ev_ext && (scan_code == STOP_CODE)) ||
                      (pause_done && PAUSE_IS_STOP);
  assign push_data  = {scan_code, ev_ext, shift, ctrl, alt};

  assign full    = (count == FULL_LEVEL);
  assign pop     = read_kb && (count != '0);
  assign push_ok = push_req && (!full || pop);
  assign rd_next = rd_ptr + 1'b1;

  // Prefix decoder plus the modifier and held-key tracking it drives.
  always_ff @(posedge mclk25 or posedge reset_in) begin
    if (reset_in) begin
      state     <= S_IDLE;
      skip_cnt  <= '0;
      mods      <= '0;
      last_make <= '0;
      key_down  <= 1'b0;
    end else begin
      if (scan_err) begin
        state <= S_IDLE;
      end else if (scan_dav) begin
        case (state)
          S_IDLE: begin
            if (scan_code == 8'hE0)      state <= S_EXT;
            else if (scan_code == 8'hF0) state <= S_BRK;
            else if (scan_code == 8'hE1) begin
              state    <= S_PAUSE;
              skip_cnt <= 3'd7;
            end
          end
          S_EXT: begin
            if (scan_code == 8'hF0)                             state <= S_EXT_BRK;
            else if (scan_code != 8'hE0 && scan_code != 8'hE1)  state <= S_IDLE;
          end
          S_BRK, S_EXT_BRK: state <= S_IDLE;
          S_PAUSE: begin
            if (skip_cnt == 3'd1) state <= S_IDLE;
            skip_cnt <= skip_cnt - 3'd1;
          end
          default: state <= S_IDLE;
        endcase
      end
      if (ev_make && is_mod)  mods <= mods | mod_sel;
      if (ev_break && is_mod) mods <= mods & ~mod_sel;
      if (push_req) begin
        last_make <= key_id;
        key_down  <= 1'b1;
      end
      if (ev_break && !is_mod && (key_id == last_make)) key_down <= 1'b0;
    end
  end

  always_ff @(posedge mclk25 or posedge reset_in) begin
    if (reset_in)       stop_cnt <= '0;
    else if (stop_trig) stop_cnt <= STOP_LOAD;
    else if (stop_cnt != '0) stop_cnt <= stop_cnt - 16'd1;
  end

  assign key_stop = (stop_cnt != '0);

  always_ff @(posedge mclk25) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // The head register is refreshed from storage, or straight from the push when
  // the entry being written becomes the new head, so it is valid one clock later.
  always_ff @(posedge mclk25 or posedge reset_in) begin
    if (reset_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_next;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (pop) begin
        if (count == ONE_LEVEL) begin
          if (push_ok) head <= push_data;
        end else begin
          head <= mem[rd_next];
        end
      end else if (count == '0 && push_ok) begin
        head <= push_data;
      end
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (ovf_clr)             overflow <= 1'b0;
    end
  end

  assign {key_code, key_ext, key_shift, key_ctrl, key_alt} = head;
  assign kbd_available = (count != '0);
  assign fifo_level    = count;

endmodule

// File: tb/tb_kbd_fifo_intf.sv
// Bench for kbd_fifo_intf: a default instance and a small non-filtering one share
// stimulus; both are checked against a byte-level behavioural model.
module tb_kbd_fifo_intf;

  logic       mclk25 = 1'b0;
  logic       reset_in = 1'b1;
  logic [7:0] scan_code = '0;
  logic       scan_dav = 1'b0, scan_err = 1'b0, read_kb = 1'b0, ovf_clr = 1'b0;

  logic [7:0] a_code, b_code;
  logic       a_ext, a_kshift, a_kctrl, a_kalt, a_avail, a_ovf, a_shift, a_ctrl, a_alt, a_kdown, a_stop;
  logic       b_ext, b_kshift, b_kctrl, b_kalt, b_avail, b_ovf, b_shift, b_ctrl, b_alt, b_kdown, b_stop;
  logic [3:0] a_level;
  logic [2:0] b_level;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 mclk25 = ~mclk25;

  kbd_fifo_intf dut_a (
    .mclk25(mclk25), .reset_in(reset_in), .scan_code(scan_code), .scan_dav(scan_dav),
    .scan_err(scan_err), .read_kb(read_kb), .ovf_clr(ovf_clr),
    .key_code(a_code), .key_ext(a_ext), .key_shift(a_kshift), .key_ctrl(a_kctrl), .key_alt(a_kalt),
    .kbd_available(a_avail), .fifo_level(a_level), .overflow(a_ovf),
    .shift(a_shift), .ctrl(a_ctrl), .alt(a_alt), .key_down(a_kdown), .key_stop(a_stop)
  );

  kbd_fifo_intf #(.DEPTH_LOG2(2), .STOP_PULSE(5), .PAUSE_IS_STOP(1'b0), .FILTER_REPEAT(1'b0)) dut_b (
    .mclk25(mclk25), .reset_in(reset_in), .scan_code(scan_code), .scan_dav(scan_dav),
    .scan_err(scan_err), .read_kb(read_kb), .ovf_clr(ovf_clr),
    .key_code(b_code), .key_ext(b_ext), .key_shift(b_kshift), .key_ctrl(b_kctrl), .key_alt(b_kalt),
    .kbd_available(b_avail), .fifo_level(b_level), .overflow(b_ovf),
    .shift(b_shift), .ctrl(b_ctrl), .alt(b_alt), .key_down(b_kdown), .key_stop(b_stop)
  );

  // Model state per instance; prefixes are tracked as flags and a pause byte budget.
  logic [5:0]  m_mods [2];
  logic [8:0]  m_last [2];
  bit          m_ext [2], m_brk [2], m_kd [2], m_ovf [2];
  int          m_pause [2], m_stop [2];
  logic [11:0] q0 [$];
  logic [11:0] q1 [$];

  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [11:0] qfront(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic int mod_index(input bit e, input logic [7:0] b);
    if (!e && b == 8'h12) return 0;
    if (!e && b == 8'h59) return 1;
    if (!e && b == 8'h14) return 2;
    if ( e && b == 8'h14) return 3;
    if (!e && b == 8'h11) return 4;
    if ( e && b == 8'h11) return 5;
    return -1;
  endfunction

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_mods[i] = '0; m_last[i] = '0; m_ext[i] = 0; m_brk[i] = 0;
      m_kd[i] = 0; m_ovf[i] = 0; m_pause[i] = 0; m_stop[i] = 0;
    end
  endtask

  task automatic model_inst(input int i);
    int          depth = (i == 0) ? 8 : 4;
    int          pulse = (i == 0) ? 256 : 5;
    bit          filt = (i == 0);
    bit          pstop = (i == 0);
    bit          trig = 0, pushreq = 0, popd, setovf = 0;
    int          idx;
    logic [5:0]  mb = m_mods[i];
    logic [11:0] ent = '0;
    if (scan_err) begin
      m_ext[i] = 0; m_brk[i] = 0; m_pause[i] = 0;
    end else if (scan_dav) begin
      if (m_pause[i] > 0) begin
        m_pause[i]--;
        if (m_pause[i] == 0 && pstop) trig = 1;
      end else if (m_brk[i]) begin
        idx = mod_index(m_ext[i], scan_code);
        if (idx >= 0) m_mods[i][idx] = 1'b0;
        else if (m_last[i] == {m_ext[i], scan_code}) m_kd[i] = 0;
        m_ext[i] = 0; m_brk[i] = 0;
      end else if (scan_code == 8'hF0) m_brk[i] = 1;
      else if (scan_code == 8'hE0) m_ext[i] = 1;
      else if (scan_code == 8'hE1) begin
        if (!m_ext[i]) m_pause[i] = 7;
      end else begin
        idx = mod_index(m_ext[i], scan_code);
        if (idx >= 0) m_mods[i][idx] = 1'b1;
        else if (!(filt && m_kd[i] && m_last[i] == {m_ext[i], scan_code})) begin
          m_last[i] = {m_ext[i], scan_code};
          m_kd[i] = 1;
          pushreq = 1;
          ent = {scan_code, m_ext[i], mb[0] | mb[1], mb[2] | mb[3], mb[4] | mb[5]};
          if (!m_ext[i] && scan_code == 8'h07) trig = 1;
        end
        m_ext[i] = 0;
      end
    end
    popd = read_kb && qsize(i) > 0;
    if (popd) begin
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
    if (pushreq) begin
      if (qsize(i) >= depth) setovf = 1;
      else if (i == 0) q0.push_back(ent);
      else q1.push_back(ent);
    end
    if (setovf) m_ovf[i] = 1;
    else if (ovf_clr) m_ovf[i] = 0;
    if (trig) m_stop[i] = pulse;
    else if (m_stop[i] > 0) m_stop[i]--;
  endtask

  task automatic step();
    model_inst(0);
    model_inst(1);
    @(posedge mclk25);
    #1;
    scan_dav = 0; scan_err = 0; read_kb = 0; ovf_clr = 0;
  endtask

  task automatic send(input logic [7:0] b);
    scan_code = b;
    scan_dav = 1;
    step();
  endtask

  task automatic pop_one();
    read_kb = 1;
    step();
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge mclk25);
    @(negedge mclk25);
    reset_in = 0;
    n_cmp++;
    if ({a_avail, a_ovf, a_shift, a_ctrl, a_alt, a_kdown, a_stop} !== 7'b0) begin
      n_fail++; $display("[TB] FAIL reset_flags: got %b want 0000000", {a_avail, a_ovf, a_shift, a_ctrl, a_alt, a_kdown, a_stop});
    end
    n_cmp++;
    if (a_level !== 4'd0 || b_level !== 3'd0) begin
      n_fail++; $display("[TB] FAIL reset_level: got %0d/%0d want 0/0", a_level, b_level);
    end
    n_cmp++;
    if (a_code !== 8'h00) begin
      n_fail++; $display("[TB] FAIL reset_code: got %h want 00", a_code);
    end
    step();
  endtask

  task automatic test_basic();
    send(8'h1C);
    n_cmp++;
    if (a_avail !== 1'b1 || a_code !== 8'h1C || a_ext !== 1'b0) begin
      n_fail++; $display("[TB] FAIL basic_head: got avail=%b code=%h ext=%b want 1/1c/0", a_avail, a_code, a_ext);
    end
    n_cmp++;
    if ({a_kshift, a_kctrl, a_kalt, a_kdown} !== 4'b0001) begin
      n_fail++; $display("[TB] FAIL basic_mods_down: got %b want 0001", {a_kshift, a_kctrl, a_kalt, a_kdown});
    end
    send(8'hF0);
    send(8'h1C);
    n_cmp++;
    if (a_kdown !== 1'b0 || a_level !== 4'd1) begin
      n_fail++; $display("[TB] FAIL basic_break: got down=%b level=%0d want 0/1", a_kdown, a_level);
    end
    pop_one();
    n_cmp++;
    if (a_level !== 4'd0 || a_avail !== 1'b0 || b_level !== 3'd0) begin
      n_fail++; $display("[TB] FAIL basic_pop: got level=%0d avail=%b blevel=%0d want 0/0/0", a_level, a_avail, b_level);
    end
  endtask

  task automatic test_modifiers();
    send(8'h12);
    n_cmp++;
    if (a_shift !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mod_shift_on: got %b want 1", a_shift);
    end
    send(8'h1C);
    n_cmp++;
    if (a_code !== 8'h1C || a_kshift !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mod_snapshot: got code=%h shift=%b want 1c/1", a_code, a_kshift);
    end
    send(8'hF0); send(8'h12);
    n_cmp++;
    if (a_shift !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mod_shift_off: got %b want 0", a_shift);
    end
    pop_one();
    send(8'hE0); send(8'h14);
    n_cmp++;
    if (a_ctrl !== 1'b1 || a_level !== 4'd0) begin
      n_fail++; $display("[TB] FAIL mod_rctrl: got ctrl=%b level=%0d want 1/0", a_ctrl, a_level);
    end
    send(8'hE0); send(8'h75);
    n_cmp++;
    if ({a_code, a_ext, a_kshift, a_kctrl, a_kalt} !== {8'h75, 4'b1010}) begin
      n_fail++; $display("[TB] FAIL mod_ext_entry: got %h/%b want 75/1010", a_code, {a_ext, a_kshift, a_kctrl, a_kalt});
    end
    send(8'hE0); send(8'hF0); send(8'h14);
    send(8'hE0); send(8'hF0); send(8'h75);
    n_cmp++;
    if (a_ctrl !== 1'b0 || a_kdown !== 1'b0) begin
      n_fail++; $display("[TB] FAIL mod_ext_release: got ctrl=%b down=%b want 0/0", a_ctrl, a_kdown);
    end
    pop_one();
  endtask

  task automatic test_repeat();
    repeat (5) send(8'h1C);
    n_cmp++;
    if (a_level !== 4'd1 || b_level !== 3'd4) begin
      n_fail++; $display("[TB] FAIL repeat_levels: got %0d/%0d want 1/4", a_level, b_level);
    end
    n_cmp++;
    if (b_ovf !== 1'b1 || a_ovf !== 1'b0) begin
      n_fail++; $display("[TB] FAIL repeat_ovf: got a=%b b=%b want 0/1", a_ovf, b_ovf);
    end
    send(8'hF0); send(8'h1C);
    ovf_clr = 1;
    repeat (5) pop_one();
    n_cmp++;
    if (a_level !== 4'd0 || b_level !== 3'd0 || b_ovf !== 1'b0) begin
      n_fail++; $display("[TB] FAIL repeat_drain: got %0d/%0d ovf=%b want 0/0/0", a_level, b_level, b_ovf);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    logic [7:0] exp_b [4] = '{8'h1D, 8'h24, 8'h2D, 8'h4B};
    for (int k = 0; k < 9; k++) send(codes[k]);
    n_cmp++;
    if (b_level !== 3'd4 || b_ovf !== 1'b1 || b_code !== 8'h15) begin
      n_fail++; $display("[TB] FAIL ovf_small: got level=%0d ovf=%b head=%h want 4/1/15", b_level, b_ovf, b_code);
    end
    n_cmp++;
    if (a_level !== 4'd8 || a_ovf !== 1'b1) begin
      n_fail++; $display("[TB] FAIL ovf_big: got level=%0d ovf=%b want 8/1", a_level, a_ovf);
    end
    read_kb = 1;
    send(8'h4B);
    n_cmp++;
    if (b_level !== 3'd4 || b_ovf !== 1'b1 || a_level !== 4'd8 || b_code !== 8'h1D) begin
      n_fail++; $display("[TB] FAIL ovf_push_pop: got %0d/%b/%0d/%h want 4/1/8/1d", b_level, b_ovf, a_level, b_code);
    end
    ovf_clr = 1;
    step();
    n_cmp++;
    if (a_ovf !== 1'b0 || b_ovf !== 1'b0) begin
      n_fail++; $display("[TB] FAIL ovf_clear: got %b/%b want 0/0", a_ovf, b_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (b_code !== exp_b[k]) begin
        n_fail++; $display("[TB] FAIL ovf_order%0d: got %h want %h", k, b_code, exp_b[k]);
      end
      pop_one();
    end
    repeat (4) pop_one();
    n_cmp++;
    if (a_level !== 4'd0 || b_level !== 3'd0) begin
      n_fail++; $display("[TB] FAIL ovf_drain: got %0d/%0d want 0/0", a_level, b_level);
    end
  endtask

  task automatic test_stop();
    int hi;
    send(8'h07);
    n_cmp++;
    if (a_code !== 8'h07 || a_level !== 4'd1) begin
      n_fail++; $display("[TB] FAIL stop_entry: got %h level=%0d want 07/1", a_code, a_level);
    end
    hi = a_stop ? 1 : 0;
    for (int k = 0; k < 400 && a_stop; k++) begin
      step();
      if (a_stop) hi++;
    end
    n_cmp++;
    if (hi != 256) begin
      n_fail++; $display("[TB] FAIL stop_width: got %0d want 256", hi);
    end
    send(8'hF0); send(8'h07);
    send(8'h07);
    hi = a_stop ? 1 : 0;
    repeat (96) begin
      step();
      if (a_stop) hi++;
    end
    send(8'hF0); if (a_stop) hi++;
    send(8'h07); if (a_stop) hi++;
    send(8'h07); if (a_stop) hi++;
    for (int k = 0; k < 400 && a_stop; k++) begin
      step();
      if (a_stop) hi++;
    end
    n_cmp++;
    if (hi != 355) begin
      n_fail++; $display("[TB] FAIL stop_retrigger: got %0d want 355", hi);
    end
    repeat (6) pop_one();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int k = 0; k < 8; k++) send(seq[k]);
    n_cmp++;
    if (a_stop !== 1'b1 || b_stop !== 1'b0) begin
      n_fail++; $display("[TB] FAIL pause_stop: got %b/%b want 1/0", a_stop, b_stop);
    end
    n_cmp++;
    if (a_level !== 4'd0 || b_level !== 3'd0 || a_ctrl !== 1'b0) begin
      n_fail++; $display("[TB] FAIL pause_quiet: got %0d/%0d ctrl=%b want 0/0/0", a_level, b_level, a_ctrl);
    end
    repeat (260) step();
  endtask

  task automatic test_scan_err();
    send(8'hE0);
    scan_err = 1;
    step();
    send(8'h1C);
    n_cmp++;
    if (a_level !== 4'd1 || a_code !== 8'h1C || a_ext !== 1'b0) begin
      n_fail++; $display("[TB] FAIL err_prefix: got %0d/%h/%b want 1/1c/0", a_level, a_code, a_ext);
    end
    scan_err = 1;
    send(8'hF0);
    send(8'h1C);
    n_cmp++;
    if (a_kdown !== 1'b1 || a_level !== 4'd1 || b_level !== 3'd2) begin
      n_fail++; $display("[TB] FAIL err_drop: got down=%b %0d/%0d want 1/1/2", a_kdown, a_level, b_level);
    end
    repeat (2) pop_one();
  endtask

  task automatic test_async_reset();
    send(8'h12); send(8'h2B); send(8'h07); send(8'hE0);
    #2 reset_in = 1;
    #1;
    n_cmp++;
    if ({a_avail, a_ovf, a_shift, a_kdown, a_stop, b_avail, b_shift, b_kdown} !== 8'b0 || a_level !== 4'd0 || a_code !== 8'h00) begin
      n_fail++; $display("[TB] FAIL async_reset: got %b level=%0d code=%h want 0", {a_avail, a_ovf, a_shift, a_kdown, a_stop, b_avail, b_shift, b_kdown}, a_level, a_code);
    end
    model_reset();
    @(negedge mclk25);
    reset_in = 0;
    step();
    send(8'h1C);
    n_cmp++;
    if (a_code !== 8'h1C || a_ext !== 1'b0 || a_level !== 4'd1) begin
      n_fail++; $display("[TB] FAIL async_recover: got %h/%b/%0d want 1c/0/1", a_code, a_ext, a_level);
    end
    pop_one();
  endtask

  task automatic test_random();
    logic [7:0]  pool [14] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h1C, 8'h1B, 8'h07,
                               8'hE0, 8'hF0, 8'hE1, 8'h23, 8'h75, 8'hE0, 8'hF0};
    logic [11:0] oh;
    logic [3:0]  olev;
    logic [6:0]  ofl, efl;
    for (int c = 0; c < 1500; c++) begin
      scan_dav  = ($urandom_range(0, 1) == 1);
      scan_code = pool[$urandom_range(0, 13)];
      scan_err  = ($urandom_range(0, 39) == 0);
      read_kb   = ($urandom_range(0, 2) == 0);
      ovf_clr   = ($urandom_range(0, 29) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          oh = {a_code, a_ext, a_kshift, a_kctrl, a_kalt};
          olev = a_level;
          ofl = {a_avail, a_ovf, a_shift, a_ctrl, a_alt, a_kdown, a_stop};
        end else begin
          oh = {b_code, b_ext, b_kshift, b_kctrl, b_kalt};
          olev = {1'b0, b_level};
          ofl = {b_avail, b_ovf, b_shift, b_ctrl, b_alt, b_kdown, b_stop};
        end
        efl = {qsize(i) > 0, m_ovf[i], m_mods[i][0] | m_mods[i][1], m_mods[i][2] | m_mods[i][3],
               m_mods[i][4] | m_mods[i][5], m_kd[i], m_stop[i] > 0};
        n_cmp++;
        if (olev !== 4'(qsize(i)) || ofl !== efl) begin
          n_fail++; $display("[TB] FAIL rand_state c=%0d i=%0d: got level=%0d flags=%b want %0d/%b", c, i, olev, ofl, qsize(i), efl);
        end
        if (qsize(i) > 0) begin
          n_cmp++;
          if (oh !== qfront(i)) begin
            n_fail++; $display("[TB] FAIL rand_head c=%0d i=%0d: got %h want %h", c, i, oh, qfront(i));
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modifiers();
    test_repeat();
    test_overflow();
    test_stop();
    test_pause();
    test_scan_err();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_fifo_intf.md
Name: kbd_fifo_intf

Overview:
- Parametrised successor keyboard front end.
- Consumes the PS/2 scan byte stream (scan_code with a scan_dav strobe) from the PS/2 controller.
- Decodes E0 extended, F0 break and E1 pause sequences, and tracks the shift/ctrl/alt modifiers.
- Queues make events, with a modifier snapshot, in a first-word-fall-through FIFO. The ASCII translator and the CPU register interface read from this FIFO, so keystrokes are no longer lost while the CPU is slow to read.
- Also generates the STOP pulse and the any-key-down flag.

Parameters:
- DEPTH_LOG2, 3: FIFO depth = 2**DEPTH_LOG2 entries (legal range 1..6).
- STOP_CODE, 8'h07: non-extended make code that fires key_stop.
- STOP_PULSE, 256: key_stop high time in clocks (legal range 1..65535).
- PAUSE_IS_STOP, 1: 1 = the complete Pause sequence also fires key_stop.
- FILTER_REPEAT, 1: 1 = drop typematic repeats of the currently held key.

Ports:
- mclk25  in  1  system clock.
- reset_in  in  1  asynchronous reset, active-high.
- scan_code  in  8  byte from the PS/2 controller; valid when scan_dav=1.
- scan_dav  in  1  one-clock strobe: scan_code valid.
- scan_err  in  1  one-clock strobe: framing/parity error.
- read_kb  in  1  one-clock pop of the FIFO head.
- ovf_clr  in  1  clears the overflow flag.
- key_code  out  8  head entry scan code.
- key_ext  out  1  head entry was E0-prefixed.
- key_shift  out  1  head entry snapshot: shift.
- key_ctrl  out  1  head entry snapshot: ctrl.
- key_alt  out  1  head entry snapshot: alt.
- kbd_available  out  1  FIFO not empty.
- fifo_level  out  DEPTH_LOG2+1  number of entries held.
- overflow  out  1  sticky: a make event was dropped because the FIFO was full.
- shift  out  1  live shift state (left OR right).
- ctrl  out  1  live ctrl state (left OR right).
- alt  out  1  live alt state (left OR right).
- key_down  out  1  a non-modifier key is held.
- key_stop  out  1  STOP pulse.

Behaviour:
- Reset (asynchronous, reset_in=1): all outputs 0; FIFO empty; decoder in IDLE; last_make cleared; stop counter 0.
- Decoder FSM. It advances only on scan_dav. States and transitions:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with skip count 7.
    - any other byte -> process make(ext=0) and stay in IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 or E1 -> stay in EXT (byte ignored).
    - any other byte -> process make(ext=1), then IDLE.
  - BRK: any byte -> process break(ext=0), then IDLE.
  - EXT_BRK: any byte -> process break(ext=1), then IDLE.
  - PAUSE: decrement the skip count on each byte. When the 7th byte is consumed, go to IDLE; if PAUSE_IS_STOP=1, also trigger stop. Pause bytes are never queued and do not change modifiers.
- scan_err, in any state: the FSM goes to IDLE in the same cycle and any partial prefix is discarded. Modifiers, FIFO and key_down are unchanged. If scan_err and scan_dav arrive in the same cycle, scan_err wins and the byte is dropped.
- Modifier codes:
  - Shift: 12, 59.
  - Ctrl: 14, E0 14.
  - Alt: 11, E0 11.
  - Left and right of each modifier are tracked separately; the outputs are the OR of the pair.
  - A make sets the corresponding bit; a break clears it.
  - Modifiers are never queued and never affect key_down or last_make.
- Make of a non-modifier key:
  - If FILTER_REPEAT=1, key_down=1 and {ext,code} equals last_make: the event is dropped, with no other effect.
  - Otherwise:
    - last_make <= {ext,code}; key_down <= 1.
    - Push {code, ext, shift, ctrl, alt}. The snapshot uses the modifier state before this byte.
    - If ext=0 and code=STOP_CODE: trigger stop. STOP_CODE is also pushed.
- Break of a non-modifier key:
  - If {ext,code} equals last_make, key_down <= 0.
  - Otherwise the break is ignored; key_down stays set.
- FIFO:
  - Latency: a scan_dav at cycle N is visible on the head outputs and on kbd_available at cycle N+1.
  - read_kb while empty: ignored.
  - Push when full with no read_kb: entry dropped, overflow <= 1.
  - Push and read_kb in the same cycle while full: both succeed; level unchanged; no overflow.
  - Push and read_kb in the same cycle while empty: the push succeeds and the pop is ignored.
  - Read/write pointers wrap modulo depth.
  - fifo_level saturates at 2**DEPTH_LOG2.
  - overflow is cleared only by ovf_clr or reset. If ovf_clr and a new overflow occur in the same cycle, the set wins.
  - Head outputs hold their last values while empty; they are don't-care for the consumer.
- Stop:
  - A trigger loads counter = STOP_PULSE.
  - key_stop = (counter != 0); the counter decrements each clock.
  - The pulse starts at N+1 and lasts exactly STOP_PULSE clocks.
  - A re-trigger during a pulse reloads the counter, extending the pulse.

Test Plan:
- Bytes 1C, F0 1C -> one entry {1C, ext=0, mods=000}; key_down=1 after the make and 0 after the break; kbd_available at N+1; read_kb -> level 0.
- Bytes 12, 1C, F0 12 -> shift=1 then 0; entry {1C, shift=1}. Then bytes E0 14, E0 75 -> entry {75, ext=1, ctrl=1}.
- Bytes 1C x5 with FILTER_REPEAT=1 -> one entry. The same sequence with FILTER_REPEAT=0 -> five entries.
- DEPTH_LOG2=2: 5 distinct makes with no reads -> level=4, overflow=1, first four codes retained in order. Then push with simultaneous read_kb while full -> level stays 4, overflow unchanged; ovf_clr -> overflow=0.
- Byte 07 -> entry {07} and key_stop high for exactly 256 clocks. A second 07 at clock 100 -> the pulse ends 256 clocks after the second trigger.
- E1 14 77 E1 F0 14 F0 77 -> no entries, key_stop pulse fired. Separately, E0 then scan_err then 1C -> entry {1C, ext=0}. Assert reset_in mid-sequence (asynchronous) -> all outputs 0 immediately.
